ofifo_deskew: RTL

//  Output-side collector for the systolic array; the counterpart of the L0 input bank.
//  L0 is written one full row per cycle and read with a staggered per-row enable.

---
 rtl/ofifo_deskew_if.sv | 25 ++
 rtl/ofifo_deskew.sv | 88 ++++++++
 2 files changed

// File: rtl/ofifo_deskew_if.sv
// Handshake/data bundle between the systolic array columns, the deskew FIFO and the writeback path.
interface ofifo_deskew_if #(
  parameter int unsigned col = 8,
  parameter int unsigned bw  = 16
);
  logic [col-1:0]    wr;
  logic [col*bw-1:0] in;
  logic              rd;
  logic [col*bw-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_overflow;
  logic [15:0]       o_count;

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_ready, o_overflow, o_count
  );

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_ready, o_overflow, o_count
  );
endinterface

// File: rtl/ofifo_deskew.sv
// Output-side deskew FIFO: lanes are written independently as PE results trickle out,
// and read back one aligned row per pop.
module ofifo_deskew #(
  parameter int unsigned col   = 8,
  parameter int unsigned bw    = 16,
  parameter int unsigned depth = 64
) (
  input logic           clk,
  input logic           reset,
  ofifo_deskew_if.slave bus
);
  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned pw = aw + 1;

  logic [col-1:0] lane_empty;
  logic [col-1:0] lane_full;
  logic [bw-1:0]  out_lane [col];
  logic           valid_c;
  logic           pop_c;
  logic           overflow_q;
  logic [15:0]    count_q;

  assign valid_c = &(~lane_empty);
  assign pop_c   = bus.rd & valid_c;

  for (genvar g = 0; g < col; g++) begin : g_lane
    logic [bw-1:0] ram [depth];
    logic [pw-1:0] wptr;
    logic [pw-1:0] rptr;
    logic          push_c;

    // Full is judged on the registered pointers only, so a same-cycle pop never frees a slot.
    assign lane_empty[g] = (wptr == rptr);
    assign lane_full[g]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign push_c        = bus.wr[g] & ~lane_full[g];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
      if (!reset && push_c) begin
        ram[wptr[aw-1:0]] <= bus.in[g*bw +: bw];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr        <= '0;
        rptr        <= '0;
        out_lane[g] <= '0;
      end else begin
        if (push_c) begin
          wptr <= wptr + pw'(1);
        end
        if (pop_c) begin
          rptr        <= rptr + pw'(1);
          out_lane[g] <= ram[rptr[aw-1:0]];
        end
      end
    end
  end

  // Sticky overflow and popped-row counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (|(bus.wr & lane_full)) begin
        overflow_q <= 1'b1;
      end
      if (pop_c) begin
        count_q <= count_q + 16'(1);
      end
    end
  end

  always_comb begin
    bus.out = '0;
    for (int i = 0; i < col; i++) begin
      bus.out[i*bw +: bw] = out_lane[i];
    end
  end

  assign bus.o_valid    = valid_c;
  assign bus.o_full     = |lane_full;
  assign bus.o_ready    = ~(|lane_full);
  assign bus.o_overflow = overflow_q;
  assign bus.o_count    = count_q;
endmodule
